// File: rtl/fft_frame_buffer.sv
// Ping-pong frame buffer between the window and the FFT core: collects index-0-aligned
// frames into one of two banks and streams completed frames out over valid/ready/last.
//
// write state | meaning
// SYNC        | waiting for an index-0 marker, samples discarded
// FILL        | writing the current frame into bank wb
// DROP        | both banks occupied at frame start, discarding until the next marker
module fft_frame_buffer #(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 4096
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] in_sample,
    input  logic             in_valid,
    input  logic             in_first,
    output logic [WIDTH-1:0] m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic             m_tlast,
    output logic             overflow,
    output logic             resync,
    output logic [15:0]      frames_dropped
);

    localparam int AW = $clog2(FRAME_LEN);
    localparam logic [AW-1:0] LAST = AW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {SYNC, FILL, DROP} wr_state_t;

    wr_state_t         state;
    logic [AW-1:0]     widx;
    logic [AW-1:0]     ridx;
    logic              wb;
    logic              rb;
    logic [1:0]        full;
    logic              rd_active;
    logic              rd_fetched;
    logic [WIDTH-1:0]  mem [0:2*FRAME_LEN-1];

    logic              frame_start;
    logic              rd_release;
    logic              wb_free;
    logic              fill_write;
    logic              we;
    logic [AW:0]       waddr;
    logic              full_set;
    logic [1:0]        set_mask;
    logic [1:0]        clr_mask;
    logic              rd_load;

    assign frame_start = in_valid && in_first;
    assign rd_release  = m_tvalid && m_tready && m_tlast;
    // A bank handed back by the reader this cycle is already usable by a new frame.
    assign wb_free     = !full[wb] || (rd_release && (rb == wb));
    assign fill_write  = (state == FILL) && in_valid && !in_first;
    assign we          = (frame_start && wb_free) || fill_write;
    assign waddr       = {wb, (frame_start ? {AW{1'b0}} : widx)};
    assign full_set    = fill_write && (widx == LAST);
    assign set_mask    = {full_set && wb, full_set && !wb};
    assign clr_mask    = {rd_release && rb, rd_release && !rb};
    assign rd_load     = rd_active && !rd_fetched && (!m_tvalid || m_tready);

    always_ff @(posedge clk_in) begin
        if (we) begin
            mem[waddr] <= in_sample;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            full <= 2'b00;
        end else begin
            full <= (full & ~clr_mask) | set_mask;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state          <= SYNC;
            widx           <= '0;
            wb             <= 1'b0;
            overflow       <= 1'b0;
            resync         <= 1'b0;
            frames_dropped <= 16'd0;
        end else begin
            overflow <= 1'b0;
            resync   <= 1'b0;
            if (frame_start) begin
                if (state == FILL) begin
                    resync <= 1'b1;
                end
                if (wb_free) begin
                    state <= FILL;
                    widx  <= AW'(1);
                end else begin
                    state    <= DROP;
                    widx     <= '0;
                    overflow <= 1'b1;
                    if (frames_dropped != 16'hFFFF) begin
                        frames_dropped <= frames_dropped + 16'd1;
                    end
                end
            end else if (fill_write) begin
                if (widx == LAST) begin
                    state <= SYNC;
                    widx  <= '0;
                    wb    <= ~wb;
                end else begin
                    widx <= widx + AW'(1);
                end
            end
        end
    end

    // m_tdata doubles as the RAM output register; it only advances when empty or consumed.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rb         <= 1'b0;
            ridx       <= '0;
            rd_active  <= 1'b0;
            rd_fetched <= 1'b0;
            m_tvalid   <= 1'b0;
            m_tlast    <= 1'b0;
            m_tdata    <= '0;
        end else begin
            if (!rd_active) begin
                if (full[rb]) begin
                    rd_active  <= 1'b1;
                    ridx       <= '0;
                    rd_fetched <= 1'b0;
                end
            end else if (rd_release) begin
                rd_active  <= 1'b0;
                rd_fetched <= 1'b0;
                rb         <= ~rb;
            end

            if (rd_load) begin
                m_tdata  <= mem[{rb, ridx}];
                m_tvalid <= 1'b1;
                m_tlast  <= (ridx == LAST);
                ridx     <= ridx + AW'(1);
                if (ridx == LAST) begin
                    rd_fetched <= 1'b1;
                end
            end else if (m_tvalid && m_tready) begin
                m_tvalid <= 1'b0;
                m_tlast  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fft_frame_buffer.sv
// Scoreboard bench for fft_frame_buffer with FRAME_LEN=16: expected samples are queued as
// frames are driven and compared against the stream whenever m_tvalid is high.
module tb_fft_frame_buffer;

    localparam int W  = 8;
    localparam int FL = 16;

    logic          clk = 1'b0;
    logic          rst_in;
    logic [W-1:0]  in_sample;
    logic          in_valid;
    logic          in_first;
    logic [W-1:0]  m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;
    logic          overflow;
    logic          resync;
    logic [15:0]   frames_dropped;

    logic [W:0]    sb [$];
    int            checks = 0;
    int            errors = 0;
    int            ovf_seen = 0;
    int            rsy_seen = 0;

    fft_frame_buffer #(.WIDTH(W), .FRAME_LEN(FL)) dut (
        .clk_in         (clk),
        .rst_in         (rst_in),
        .in_sample      (in_sample),
        .in_valid       (in_valid),
        .in_first       (in_first),
        .m_tdata        (m_tdata),
        .m_tvalid       (m_tvalid),
        .m_tready       (m_tready),
        .m_tlast        (m_tlast),
        .overflow       (overflow),
        .resync         (resync),
        .frames_dropped (frames_dropped)
    );

    always #5 clk = ~clk;

    // Whatever is presented must be the scoreboard head, stalled or not; pop on transfer.
    always @(negedge clk) begin
        if (overflow === 1'b1) ovf_seen++;
        if (resync === 1'b1) rsy_seen++;
        if (m_tvalid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL stream_extra: got last=%0b data=%h, required nothing (queue empty)",
                         m_tlast, m_tdata);
            end else begin
                if ({m_tlast, m_tdata} !== sb[0]) begin
                    errors++;
                    $display("FAIL stream_data: got last=%0b data=%h, required last=%0b data=%h",
                             m_tlast, m_tdata, sb[0][W], sb[0][W-1:0]);
                end
                if (m_tready === 1'b1) void'(sb.pop_front());
            end
        end
    end

    task automatic send(input logic [W-1:0] d, input logic f);
        in_sample = d;
        in_valid  = 1'b1;
        in_first  = f;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_first  = 1'b0;
    endtask

    task automatic send_frame(input logic [W-1:0] base, input bit expect_out);
        for (int i = 0; i < FL; i++) begin
            if (expect_out) sb.push_back({(i == FL - 1), base + W'(i)});
            send(base + W'(i), (i == 0));
        end
    endtask

    task automatic drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && m_tvalid !== 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_in = 1'b1;
        in_sample = '0;
        in_valid = 1'b0;
        in_first = 1'b0;
        m_tready = 1'b1;
        repeat (2) @(negedge clk);
        checks += 6;
        if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b, required 0", m_tvalid); end
        if (m_tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast: got %b, required 0", m_tlast); end
        if (m_tdata !== 8'h00) begin errors++; $display("FAIL rst_tdata: got %h, required 00", m_tdata); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %b, required 0", overflow); end
        if (resync !== 1'b0) begin errors++; $display("FAIL rst_resync: got %b, required 0", resync); end
        if (frames_dropped !== 16'd0) begin errors++; $display("FAIL rst_dropped: got %0d, required 0", frames_dropped); end
        @(posedge clk);
        #1 rst_in = 1'b0;
    endtask

    task automatic test_sync;
        bit ok;
        m_tready = 1'b1;
        for (int i = 0; i < FL; i++) begin
            sb.push_back({(i == FL - 1), W'(i)});
            send(W'(i), (i == 0));
        end
        checks++;
        if (m_tvalid !== 1'b0) begin errors++; $display("FAIL lat_edge0: tvalid got %b, required 0", m_tvalid); end
        @(posedge clk);
        #1;
        checks++;
        if (m_tvalid !== 1'b0) begin errors++; $display("FAIL lat_edge1: tvalid got %b, required 0", m_tvalid); end
        @(posedge clk);
        #1;
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== 8'h00) begin
            errors++;
            $display("FAIL lat_edge2: tvalid=%b data=%h, required tvalid=1 data=00", m_tvalid, m_tdata);
        end
        drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL sync_drain: %0d samples left, required 0", sb.size()); end
    endtask

    task automatic test_presync;
        bit ok;
        m_tready = 1'b1;
        for (int i = 0; i < 5; i++) send(8'h50 + W'(i), 1'b0);
        send_frame(8'd100, 1'b1);
        drain(ok);
        checks += 2;
        if (!ok) begin errors++; $display("FAIL presync_drain: %0d samples left, required 0", sb.size()); end
        if (frames_dropped !== 16'd0) begin errors++; $display("FAIL presync_dropped: got %0d, required 0", frames_dropped); end
    endtask

    task automatic test_back_to_back;
        bit ok;
        bit fed;
        fed = 1'b0;
        fork
            begin
                send_frame(8'h20, 1'b1);
                send_frame(8'h40, 1'b1);
                fed = 1'b1;
            end
            begin
                for (int i = 0; i < 600; i++) begin
                    @(posedge clk);
                    #1;
                    m_tready = 1'($urandom_range(0, 1));
                    if (fed && sb.size() == 0) break;
                end
                m_tready = 1'b1;
            end
        join
        drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL backpressure_drain: %0d samples left, required 0", sb.size()); end
    endtask

    task automatic test_overflow;
        bit ok;
        int base;
        base = ovf_seen;
        m_tready = 1'b0;
        send_frame(8'hA0, 1'b1);
        send_frame(8'hB0, 1'b1);
        for (int i = 0; i < FL; i++) begin
            send(8'hC0 + W'(i), (i == 0));
            if (i == 0) begin
                checks++;
                if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse: got %b, required 1", overflow); end
            end
        end
        checks++;
        if (frames_dropped !== 16'd1) begin errors++; $display("FAIL ovf_dropped: got %0d, required 1", frames_dropped); end
        repeat (3) @(posedge clk);
        #1 m_tready = 1'b1;
        drain(ok);
        checks += 2;
        if (!ok) begin errors++; $display("FAIL ovf_drain: %0d samples left, required 0", sb.size()); end
        if (ovf_seen - base != 1) begin errors++; $display("FAIL ovf_count: got %0d pulses, required 1", ovf_seen - base); end
    endtask

    task automatic test_resync;
        bit ok;
        int base;
        base = rsy_seen;
        m_tready = 1'b1;
        for (int i = 0; i < 7; i++) send(8'h60 + W'(i), (i == 0));
        for (int i = 0; i < FL; i++) begin
            sb.push_back({(i == FL - 1), 8'h70 + W'(i)});
            send(8'h70 + W'(i), (i == 0));
            if (i == 0) begin
                checks++;
                if (resync !== 1'b1) begin errors++; $display("FAIL resync_pulse: got %b, required 1", resync); end
            end
        end
        drain(ok);
        checks += 2;
        if (!ok) begin errors++; $display("FAIL resync_drain: %0d samples left, required 0", sb.size()); end
        if (rsy_seen - base != 1) begin errors++; $display("FAIL resync_count: got %0d pulses, required 1", rsy_seen - base); end
    endtask

    task automatic test_reset_mid;
        bit ok;
        bit found;
        found = 1'b0;
        m_tready = 1'b1;
        send_frame(8'h80, 1'b1);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (m_tvalid === 1'b1 && m_tdata === 8'h85) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL rstmid_index5: never presented, required data=85"); end
        #2;
        rst_in = 1'b1;
        sb.delete();
        #1;
        checks += 3;
        if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rstmid_tvalid: got %b, required 0", m_tvalid); end
        if (m_tlast !== 1'b0) begin errors++; $display("FAIL rstmid_tlast: got %b, required 0", m_tlast); end
        if (frames_dropped !== 16'd0) begin errors++; $display("FAIL rstmid_dropped: got %0d, required 0", frames_dropped); end
        @(posedge clk);
        #1 rst_in = 1'b0;
        send_frame(8'h90, 1'b1);
        drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rstmid_drain: %0d samples left, required 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_sync();
        test_presync();
        test_back_to_back();
        test_overflow();
        test_resync();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
